// File: rtl/serial_paralelo_lane_pkg.sv
// Shared PCIe lane symbols and lane state encoding.
// Imported by the serial-to-parallel lanes and the byte-joining stage.
package pcie_symbols;

  localparam int unsigned LANE_WIDTH = 8;

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] SKP = 8'h1C;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } lane_state_t;

endpackage

// File: rtl/serial_paralelo_lane_if.sv
// Bundle between a serial receive lane and its neighbours.
// The serial bit goes in; the aligned byte, its strobe and lock status come out.
interface serial_paralelo_lane_if
  import pcie_symbols::*;
#(
  parameter int unsigned WIDTH = LANE_WIDTH
);

  logic             data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;
  logic             active;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out,
    input  active
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out,
    output active
  );

endinterface

// File: rtl/sp_shift_reg.sv
// MSB-first deserialiser. The window includes the bit currently on data_in,
// so only the older WIDTH-1 bits need storage.
module sp_shift_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk2M,
  input  logic             reset_L,
  input  logic             data_in,
  output logic [WIDTH-1:0] window
);

  logic [WIDTH-2:0] sr;

  assign window = {sr, data_in};

  // Shift one bit per clock; reset clears history so no stale COM can match.
  always_ff @(posedge clk2M) begin
    if (!reset_L) begin
      sr <= '0;
    end else begin
      sr <= window[WIDTH-2:0];
    end
  end

endmodule

// File: rtl/serial_paralelo_lane.sv
// One receive lane: hunts for COM bit-by-bit, confirms byte alignment over
// LOCK_COMS consecutive COMs, then emits one byte plus strobe per WIDTH clocks.
// Falls back to hunting after COM_TIMEOUT consecutive non-COM bytes.
module serial_paralelo_lane
  import pcie_symbols::*;
#(
  parameter int unsigned     WIDTH       = LANE_WIDTH,
  parameter logic [WIDTH-1:0] COM        = pcie_symbols::COM,
  parameter int unsigned     LOCK_COMS   = 4,
  parameter int unsigned     COM_TIMEOUT = 16
) (
  input  logic                 clk2M,
  input  logic                 reset_L,
  serial_paralelo_lane_if.slave lane
);

  localparam int unsigned     BCW      = $clog2(WIDTH);
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(WIDTH - 1);
  localparam logic [3:0]      LOCK_C   = 4'(LOCK_COMS);
  localparam logic [7:0]      TMO_C    = 8'(COM_TIMEOUT);

  lane_state_t      state;
  logic [BCW-1:0]   bit_cnt;
  logic [3:0]       com_cnt;
  logic [7:0]       miss_cnt;
  logic [WIDTH-1:0] window;
  logic [WIDTH-1:0] data_out_q;
  logic             valid_q;
  logic             active_q;

  logic             boundary;
  logic             is_com;
  logic [3:0]       com_nxt;
  logic [7:0]       miss_nxt;

  sp_shift_reg #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk2M   (clk2M),
    .reset_L (reset_L),
    .data_in (lane.data_in),
    .window  (window)
  );

  assign boundary = (bit_cnt == LAST_BIT);
  assign is_com   = (window == COM);
  assign com_nxt  = (com_cnt == LOCK_C) ? com_cnt : com_cnt + 4'd1;
  assign miss_nxt = (miss_cnt == TMO_C) ? miss_cnt : miss_cnt + 8'd1;

  assign lane.data_out  = data_out_q;
  assign lane.valid_out = valid_q;
  assign lane.active    = active_q;

  // Alignment FSM with counters and registered outputs.
  always_ff @(posedge clk2M) begin
    if (!reset_L) begin
      state      <= SEARCH;
      bit_cnt    <= '0;
      com_cnt    <= '0;
      miss_cnt   <= '0;
      data_out_q <= '0;
      valid_q    <= 1'b0;
      active_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      unique case (state)
        SEARCH: begin
          if (is_com) begin
            bit_cnt <= '0;
            com_cnt <= 4'd1;
            if (LOCK_C == 4'd1) begin
              state    <= ACTIVE;
              active_q <= 1'b1;
              miss_cnt <= '0;
            end else begin
              state <= SYNC;
            end
          end
        end

        SYNC: begin
          if (boundary) begin
            bit_cnt <= '0;
            if (is_com) begin
              com_cnt <= com_nxt;
              if (com_nxt == LOCK_C) begin
                state    <= ACTIVE;
                active_q <= 1'b1;
                miss_cnt <= '0;
              end
            end else begin
              state   <= SEARCH;
              com_cnt <= '0;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ACTIVE: begin
          if (boundary) begin
            bit_cnt    <= '0;
            data_out_q <= window;
            valid_q    <= 1'b1;
            if (is_com) begin
              miss_cnt <= '0;
            end else if (miss_nxt == TMO_C) begin
              state    <= SEARCH;
              active_q <= 1'b0;
              miss_cnt <= '0;
              com_cnt  <= '0;
            end else begin
              miss_cnt <= miss_nxt;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        default: begin
          state    <= SEARCH;
          active_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
